// File: rtl/adder_chunked.sv
// ----------------------------------------------------------------------------
// adder_chunked
//
// A multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits
// per clock cycle, with a valid/ready handshake on both the operand side and
// the result side.
//
// Sequence: accept the operands in IDLE, run N = WIDTH/CHUNK ADD cycles from
// the least significant chunk upwards, then hold the result in DONE until the
// consumer takes it.
//
// Parameters
//   WIDTH     operand and result width. It must be a multiple of CHUNK.
//   CHUNK     number of bits added per clock cycle.
//
// Ports
//   clk       clock; all state changes on the rising edge.
//   reset     synchronous, active-high reset. It overrides every other event.
//   in_valid  the operands a/b/ci/sub are valid.
//   in_ready  high only in IDLE. An operand set is accepted on
//             in_valid && in_ready.
//   a, b      operands (unsigned or two's complement).
//   ci        carry-in, used in add mode only.
//   sub       0: s = a + b + ci
//             1: s = a - b (ci is ignored)
//   out_valid high only in DONE. s/co/ov are stable while it is high.
//   out_ready the consumer accepts the result.
//   s         sum or difference, modulo 2^WIDTH.
//   co        carry out of the MSB. In subtract mode, 1 means no borrow.
//   ov        two's-complement signed overflow.
// ----------------------------------------------------------------------------
module adder_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;          // already inverted for subtraction
    logic [WIDTH-1:0]  s_reg;
    logic              carry_reg;
    logic              co_reg;
    logic              ov_reg;
    logic [CW-1:0]     cnt_reg;

    logic              accept;
    logic              last_chunk;
    logic [CHUNK-1:0]  cur_a;
    logic [CHUNK-1:0]  cur_b;
    logic [CHUNK:0]    chunk_sum;
    logic              ov_last;

    // Split the registered operands into fixed chunk slices.
    logic [CHUNK-1:0]  a_chunk [N];
    logic [CHUNK-1:0]  b_chunk [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign accept     = in_valid && (state_reg == IDLE);
    assign last_chunk = (cnt_reg == CW'(N - 1));

    // Select the chunk that the counter points at.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                cur_a = a_chunk[i];
                cur_b = b_chunk[i];
            end
        end
    end

    assign chunk_sum = {1'b0, cur_a} + {1'b0, cur_b} + {{CHUNK{1'b0}}, carry_reg};

    // Carry-into-MSB XOR carry-out-of-MSB gives the same result as this test:
    // both operand MSBs agree and the sum MSB differs from them. That holds
    // because b_reg is already inverted in subtract mode.
    assign ov_last = (cur_a[CHUNK-1] == cur_b[CHUNK-1]) &&
                     (chunk_sum[CHUNK-1] != cur_a[CHUNK-1]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = ADD;
            ADD:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ov_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            // a - b is computed as a + ~b + 1.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | ci;
            cnt_reg   <= '0;
        end else if (state_reg == ADD) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_reg == CW'(i)) begin
                    s_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
            end
            carry_reg <= chunk_sum[CHUNK];
            cnt_reg   <= cnt_reg + 1'b1;
            if (last_chunk) begin
                co_reg <= chunk_sum[CHUNK];
                ov_reg <= ov_last;
            end
        end
    end

    assign s  = s_reg;
    assign co = co_reg;
    assign ov = ov_reg;

endmodule
